// File: rtl/fe_pkg.sv
// Shared types for the RV32I multi-cycle control path: opcodes, FSM states,
// PC / writeback select encodings and the legal-opcode check.
package fe_pkg;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_I_LOAD = 7'b0000011,
        OP_I_JALR = 7'b1100111,
        OP_S      = 7'b0100011,
        OP_B      = 7'b1100011,
        OP_J      = 7'b1101111,
        OP_U_LUI  = 7'b0110111,
        OP_U_AUI  = 7'b0010111
    } RV32I_OPCODE_t;

    typedef enum logic [2:0] {
        FETCH_S1     = 3'd0,
        DECODE_S2    = 3'd1,
        EXECUTE_S3   = 3'd2,
        MEMORY_S4    = 3'd3,
        WRITEBACK_S5 = 3'd4,
        HALT_S       = 3'd5
    } RV32I_CONTROL_UNIT_FSM_t;

    typedef enum logic [1:0] {
        PC_SRC_PC4    = 2'd0,
        PC_SRC_TARGET = 2'd1,
        PC_SRC_ALU    = 2'd2
    } PC_SRC_t;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2
    } WB_SEL_t;

    // True for the opcodes the core implements; anything else halts the core.
    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_I_LOAD, OP_I_JALR, OP_S,
            OP_B, OP_J, OP_U_LUI, OP_U_AUI: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_mem_timeout.sv
// Wait-cycle counter for a memory handshake. Counts cycles spent waiting
// while 'active' without 'ready' and flags 'expired' in the cycle that
// completes the MEM_TIMEOUT-th wait. MEM_TIMEOUT = 0 disables the flag.
module rv32i_mem_timeout #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
    localparam bit ENABLED = (MEM_TIMEOUT > 0);

    logic [CNT_W-1:0] count_reg;

    // Count unanswered wait cycles; clear whenever the wait ends or is abandoned.
    always_ff @(posedge clk) begin
        if (rst || !active || ready) begin
            count_reg <= '0;
        end else if (count_reg != LAST) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = ENABLED && active && (count_reg == LAST);

endmodule

// File: rtl/rv32i_control_unit.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback.
// Drives datapath strobes, memory handshakes and PC/writeback selects, and
// keeps sticky error flags plus a retired-instruction counter.
module rv32i_control_unit
    import fe_pkg::*;
#(
    parameter int INSTRET_WIDTH = 32,
    parameter int MEM_TIMEOUT   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              opcode,
    input  logic                    branch_taken,
    input  logic                    imem_ready,
    input  logic                    dmem_ready,
    output RV32I_CONTROL_UNIT_FSM_t control_unit_state,
    output logic                    imem_req,
    output logic                    ir_write,
    output logic                    target_write,
    output logic                    alu_out_write,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic                    reg_write,
    output logic [1:0]              wb_sel,
    output logic                    pc_write,
    output logic [1:0]              pc_src,
    output logic                    illegal,
    output logic                    bus_error,
    output logic [INSTRET_WIDTH-1:0] instret
);

    RV32I_CONTROL_UNIT_FSM_t state_reg, state_next;
    logic                     illegal_reg, bus_error_reg;
    logic [INSTRET_WIDTH-1:0] instret_reg;
    logic                     set_illegal, set_bus_error, retire;
    logic                     mem_expired;

    rv32i_mem_timeout #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_timeout (
        .clk    (clk),
        .rst    (rst),
        .active (state_reg == MEMORY_S4),
        .ready  (dmem_ready),
        .expired(mem_expired)
    );

    // State register, sticky flags and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= FETCH_S1;
            illegal_reg   <= 1'b0;
            bus_error_reg <= 1'b0;
            instret_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (set_illegal)   illegal_reg   <= 1'b1;
            if (set_bus_error) bus_error_reg <= 1'b1;
            if (retire)        instret_reg   <= instret_reg + 1'b1;
        end
    end

    // Next-state and per-state strobes; every strobe is masked during reset.
    always_comb begin
        state_next    = state_reg;
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        target_write  = 1'b0;
        alu_out_write = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_SEL_ALU;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_PC4;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;

        case (state_reg)
            FETCH_S1: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write   = 1'b1;
                    state_next = DECODE_S2;
                end
            end
            DECODE_S2: begin
                target_write = 1'b1;
                if (is_legal_opcode(opcode)) begin
                    state_next = EXECUTE_S3;
                end else begin
                    set_illegal = 1'b1;
                    state_next  = HALT_S;
                end
            end
            EXECUTE_S3: begin
                alu_out_write = 1'b1;
                case (opcode)
                    OP_I_LOAD, OP_S: state_next = MEMORY_S4;
                    OP_B: begin
                        pc_write   = 1'b1;
                        pc_src     = branch_taken ? PC_SRC_TARGET : PC_SRC_PC4;
                        state_next = FETCH_S1;
                    end
                    default: state_next = WRITEBACK_S5;
                endcase
            end
            MEMORY_S4: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_S);
                if (dmem_ready) begin
                    if (opcode == OP_S) begin
                        pc_write   = 1'b1;
                        state_next = FETCH_S1;
                    end else begin
                        state_next = WRITEBACK_S5;
                    end
                end else if (mem_expired) begin
                    set_bus_error = 1'b1;
                    state_next    = HALT_S;
                end
            end
            WRITEBACK_S5: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                state_next = FETCH_S1;
                case (opcode)
                    OP_I_LOAD: wb_sel = WB_SEL_MEM;
                    OP_J:      begin wb_sel = WB_SEL_PC4; pc_src = PC_SRC_TARGET; end
                    OP_I_JALR: begin wb_sel = WB_SEL_PC4; pc_src = PC_SRC_ALU;    end
                    default:   ;
                endcase
            end
            default: state_next = HALT_S;
        endcase

        if (rst) begin
            imem_req      = 1'b0;
            ir_write      = 1'b0;
            target_write  = 1'b0;
            alu_out_write = 1'b0;
            dmem_req      = 1'b0;
            dmem_we       = 1'b0;
            reg_write     = 1'b0;
            pc_write      = 1'b0;
        end
    end

    assign retire             = (state_next == FETCH_S1) && (state_reg != FETCH_S1);
    assign control_unit_state = state_reg;
    assign illegal            = illegal_reg;
    assign bus_error          = bus_error_reg;
    assign instret            = instret_reg;

endmodule

// File: tb/tb_rv32i_control_unit.sv
// Directed-vector bench for rv32i_control_unit with hand-computed expectations.
module tb_rv32i_control_unit;
    import fe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst;
    logic [6:0]              opcode;
    logic                    branch_taken;
    logic                    imem_ready;
    logic                    dmem_ready;
    RV32I_CONTROL_UNIT_FSM_t control_unit_state;
    logic                    imem_req, ir_write, target_write, alu_out_write;
    logic                    dmem_req, dmem_we, reg_write, pc_write;
    logic [1:0]              wb_sel, pc_src;
    logic                    illegal, bus_error;
    logic [31:0]             instret;

    int total = 0;
    int bad   = 0;

    rv32i_control_unit #(
        .INSTRET_WIDTH(32),
        .MEM_TIMEOUT  (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .opcode            (opcode),
        .branch_taken      (branch_taken),
        .imem_ready        (imem_ready),
        .dmem_ready        (dmem_ready),
        .control_unit_state(control_unit_state),
        .imem_req          (imem_req),
        .ir_write          (ir_write),
        .target_write      (target_write),
        .alu_out_write     (alu_out_write),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .reg_write         (reg_write),
        .wb_sel            (wb_sel),
        .pc_write          (pc_write),
        .pc_src            (pc_src),
        .illegal           (illegal),
        .bus_error         (bus_error),
        .instret           (instret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_state(input string tag, input RV32I_CONTROL_UNIT_FSM_t exp);
        chk(tag, 32'(control_unit_state), 32'(exp));
    endtask

    // Fetch cycle: present the instruction, check the fetch strobes, move to decode.
    task automatic fetch(input logic [6:0] op);
        opcode     = op;
        imem_ready = 1'b1;
        settle();
        chk_state("fetch_st", FETCH_S1);
        chk("fetch_imem_req", 32'(imem_req), 32'd1);
        chk("fetch_ir_write", 32'(ir_write), 32'd1);
        tick();
        imem_ready = 1'b0;
    endtask

    task automatic decode_exec();
        settle();
        chk_state("dec_st", DECODE_S2);
        chk("dec_target_write", 32'(target_write), 32'd1);
        tick();
        settle();
        chk_state("exe_st", EXECUTE_S3);
        chk("exe_alu_out_write", 32'(alu_out_write), 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        opcode       = 7'h00;
        branch_taken = 1'b0;
        imem_ready   = 1'b1;
        dmem_ready   = 1'b0;
        tick();
        tick();
        settle();
        chk_state("rst_st", FETCH_S1);
        chk("rst_imem_req_masked", 32'(imem_req), 32'd0);
        chk("rst_ir_write_masked", 32'(ir_write), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_instret", instret, 32'd0);
        imem_ready = 1'b0;
        rst        = 1'b0;
        settle();
        chk("idle_imem_req", 32'(imem_req), 32'd1);
        chk("idle_ir_write", 32'(ir_write), 32'd0);
        $display("txn reset done");

        // R-type, 4 cycles
        fetch(OP_R);
        decode_exec();
        tick();
        settle();
        chk_state("r_wb_st", WRITEBACK_S5);
        chk("r_reg_write", 32'(reg_write), 32'd1);
        chk("r_wb_sel", 32'(wb_sel), 32'd0);
        chk("r_pc_write", 32'(pc_write), 32'd1);
        chk("r_instret_before", instret, 32'd0);
        tick();
        settle();
        chk_state("r_back_st", FETCH_S1);
        chk("r_instret", instret, 32'd1);
        $display("txn R instret=%0d", instret);

        // Load, dmem_ready on the 4th memory cycle
        fetch(OP_I_LOAD);
        decode_exec();
        tick();
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            settle();
            chk_state("ld_mem_st", MEMORY_S4);
            chk("ld_dmem_req", 32'(dmem_req), 32'd1);
            chk("ld_dmem_we", 32'(dmem_we), 32'd0);
            tick();
        end
        dmem_ready = 1'b0;
        settle();
        chk_state("ld_wb_st", WRITEBACK_S5);
        chk("ld_wb_sel", 32'(wb_sel), 32'd1);
        chk("ld_reg_write", 32'(reg_write), 32'd1);
        tick();
        settle();
        chk("ld_instret", instret, 32'd2);
        $display("txn LOAD instret=%0d", instret);

        // Branch taken then not taken
        for (int t = 1; t >= 0; t--) begin
            fetch(OP_B);
            decode_exec();
            branch_taken = (t == 1);
            settle();
            chk("b_pc_write", 32'(pc_write), 32'd1);
            chk("b_pc_src", 32'(pc_src), 32'(t));
            chk("b_reg_write", 32'(reg_write), 32'd0);
            tick();
            settle();
            chk_state("b_back_st", FETCH_S1);
            $display("txn B taken=%0d instret=%0d", t, instret);
        end
        branch_taken = 1'b0;
        chk("b_instret", instret, 32'd4);

        // JALR then J
        fetch(OP_I_JALR);
        decode_exec();
        tick();
        settle();
        chk("jalr_wb_sel", 32'(wb_sel), 32'd2);
        chk("jalr_pc_src", 32'(pc_src), 32'd2);
        tick();
        $display("txn JALR instret=%0d", instret);
        fetch(OP_J);
        decode_exec();
        tick();
        settle();
        chk("j_wb_sel", 32'(wb_sel), 32'd2);
        chk("j_pc_src", 32'(pc_src), 32'd1);
        tick();
        settle();
        chk("j_instret", instret, 32'd6);
        $display("txn J instret=%0d", instret);

        // Zero-wait store
        fetch(OP_S);
        decode_exec();
        tick();
        dmem_ready = 1'b1;
        settle();
        chk("st_dmem_we", 32'(dmem_we), 32'd1);
        chk("st_pc_write", 32'(pc_write), 32'd1);
        chk("st_pc_src", 32'(pc_src), 32'd0);
        chk("st_reg_write", 32'(reg_write), 32'd0);
        tick();
        dmem_ready = 1'b0;
        settle();
        chk_state("st_back_st", FETCH_S1);
        chk("st_instret", instret, 32'd7);
        $display("txn S instret=%0d", instret);

        // Illegal opcode halts; fetch handshake is then ignored
        fetch(7'h7F);
        settle();
        chk("ill_target_write", 32'(target_write), 32'd1);
        tick();
        settle();
        chk_state("ill_halt_st", HALT_S);
        chk("ill_flag", 32'(illegal), 32'd1);
        imem_ready = 1'b1;
        settle();
        chk("ill_imem_req", 32'(imem_req), 32'd0);
        chk("ill_ir_write", 32'(ir_write), 32'd0);
        tick();
        imem_ready = 1'b0;
        settle();
        chk_state("ill_still_halt", HALT_S);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk_state("ill_rst_st", FETCH_S1);
        chk("ill_rst_flag", 32'(illegal), 32'd0);
        chk("ill_rst_instret", instret, 32'd0);
        $display("txn ILLEGAL recovered");

        // Store with no dmem_ready: bus error after 16 memory cycles
        fetch(OP_S);
        decode_exec();
        tick();
        for (int i = 0; i < 16; i++) begin
            settle();
            chk_state("to_mem_st", MEMORY_S4);
            tick();
        end
        settle();
        chk_state("to_halt_st", HALT_S);
        chk("to_bus_error", 32'(bus_error), 32'd1);
        chk("to_instret", instret, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("to_rst_bus_error", 32'(bus_error), 32'd0);
        $display("txn S timeout");

        // Store with dmem_ready on the 16th memory cycle: completes normally
        fetch(OP_S);
        decode_exec();
        tick();
        for (int i = 0; i < 16; i++) begin
            dmem_ready = (i == 15);
            settle();
            chk_state("late_mem_st", MEMORY_S4);
            tick();
        end
        dmem_ready = 1'b0;
        settle();
        chk_state("late_back_st", FETCH_S1);
        chk("late_bus_error", 32'(bus_error), 32'd0);
        chk("late_instret", instret, 32'd1);
        $display("txn S late-ready instret=%0d", instret);

        // Reset mid-instruction: strobes masked, nothing retires
        fetch(OP_R);
        decode_exec();
        rst = 1'b1;
        settle();
        chk("mid_alu_masked", 32'(alu_out_write), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        chk_state("mid_rst_st", FETCH_S1);
        chk("mid_rst_instret", instret, 32'd0);
        $display("txn R aborted by reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_control_unit.md
Name: rv32i_control_unit

Overview:
Multi-cycle control FSM for the RV32I single-issue core. It sequences fetch, decode, execute, memory and writeback, and publishes `control_unit_state`, which steers the ALU operand muxing (PC+4 in fetch, PC+imm in decode, opcode-selected operands in execute). It drives all datapath write strobes, memory request handshakes, and the PC/writeback selects. It also keeps a retired-instruction counter.

Parameters:
- INSTRET_WIDTH, 32: width of the retired-instruction counter.
- MEM_TIMEOUT, 16: cycles to wait for `dmem_ready` before raising a bus error. 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- opcode  in  RV32I_OPCODE_t (7)  opcode field of the instruction register
- branch_taken  in  1  branch comparator result, valid in EXECUTE_S3
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- control_unit_state  out  RV32I_CONTROL_UNIT_FSM_t  current state
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load the instruction register; also latch PC+4
- target_write  out  1  latch the ALU result (PC+imm) as branch/jump target
- alu_out_write  out  1  latch the ALU result register
- dmem_req  out  1  data memory request
- dmem_we  out  1  store when 1, load when 0 (valid with dmem_req)
- reg_write  out  1  register-file write enable
- wb_sel  out  2  0=ALU out, 1=mem data, 2=PC+4
- pc_write  out  1  update PC
- pc_src  out  2  0=PC+4, 1=latched target, 2=ALU out with bit0 cleared (JALR)
- illegal  out  1  sticky: illegal opcode seen
- bus_error  out  1  sticky: data memory timeout
- instret  out  INSTRET_WIDTH  retired-instruction count

Behaviour:
- State register only. All outputs except the sticky flags and `instret` are combinational from state, opcode and handshake inputs. While rst=1, every strobe and request is forced to 0.
- Reset values: state=FETCH_S1, illegal=0, bus_error=0, instret=0, wait counter=0.
- FETCH_S1:
  - imem_req=1, held until imem_ready.
  - On imem_ready: ir_write=1, then go to DECODE_S2. Otherwise stay in FETCH_S1.
- DECODE_S2 (1 cycle):
  - target_write=1.
  - Opcode outside the legal set (R, I, I_LOAD, I_JALR, S, B, J, U_LUI, U_AUI) → HALT_S and set illegal. Otherwise go to EXECUTE_S3.
- EXECUTE_S3 (1 cycle):
  - alu_out_write=1.
  - I_LOAD or S → MEMORY_S4.
  - B → FETCH_S1 with pc_write=1 and pc_src = branch_taken ? 1 : 0; the instruction retires.
  - All other legal opcodes → WRITEBACK_S5.
- MEMORY_S4:
  - dmem_req=1; dmem_we=1 for S, 0 for loads.
  - On dmem_ready:
    - S → FETCH_S1 with pc_write=1, pc_src=0, retire.
    - I_LOAD → WRITEBACK_S5.
  - Wait counter increments each cycle without dmem_ready and clears on leaving MEMORY_S4.
  - If the counter reaches MEM_TIMEOUT (when nonzero) → HALT_S, set bus_error.
  - dmem_ready on the same cycle the timeout is reached wins: normal completion.
- WRITEBACK_S5 (1 cycle):
  - reg_write=1 and pc_write=1, then FETCH_S1 and retire.
  - wb_sel: I_LOAD=1, J or I_JALR=2, else 0.
  - pc_src: J=1, I_JALR=2, else 0.
- HALT_S: all strobes 0. Only rst exits it.
- Retire: instret increments by 1 in every cycle that transitions into FETCH_S1 from any state other than FETCH_S1. It wraps modulo 2^INSTRET_WIDTH.
- Latency with zero-wait memory, counted from the imem_ready cycle: B=3, R/I/U/J/JALR/S=4, load=5 cycles.
- Handshakes:
  - imem_ready is ignored outside FETCH_S1; dmem_ready is ignored outside MEMORY_S4.
  - Requests are never dropped before their ready is seen, except on rst or timeout.
- Reset mid-operation: on the next edge the state becomes FETCH_S1, flags and counters clear, and no partial instruction retires.

Decomposition:
- fe_pkg holds:
  - RV32I_CONTROL_UNIT_FSM_t, extended with DECODE_S2, MEMORY_S4, WRITEBACK_S5 and HALT_S.
  - PC_SRC_t (PC4, TARGET, ALU).
  - WB_SEL_t (ALU, MEM, PC4).
  - the legal-opcode check function.
- One sub-module, rv32i_mem_timeout, holds the wait counter and compare, so it can be reused for the fetch port later.

Test Plan:
- R_TYPE with imem_ready held high → states F,D,E,W over 4 cycles; reg_write=1 and wb_sel=0 in cycle 4; instret 0→1.
- Load with dmem_ready delayed 3 cycles → dmem_req=1 and dmem_we=0 held 4 cycles, then WB with wb_sel=1; total 8 cycles.
- B_TYPE twice (branch_taken=1, then 0) → pc_write in EXECUTE with pc_src=1, then pc_src=0; reg_write never asserted; instret=2.
- JALR → WB with wb_sel=2, pc_src=2; J → wb_sel=2, pc_src=1.
- Opcode 7'h7F → HALT_S and illegal=1; imem_ready pulses produce no strobes; rst for 1 cycle → FETCH_S1, illegal=0, instret=0.
- Store with dmem_ready never asserted, MEM_TIMEOUT=16 → HALT_S after 16 MEMORY_S4 cycles, bus_error=1; repeat with dmem_ready on cycle 16 → normal retire, bus_error=0.
